// File: rtl/tug_pkg.sv
// Shared constants and types for the tug-of-war player logic.
package tug_pkg;

  localparam int LFSR_W  = 10;
  localparam int TAP_HI  = 9;
  localparam int TAP_LO  = 6;
  localparam int SCORE_W = 3;

  localparam logic [1:0] WIN_L = 2'b01;
  localparam logic [1:0] WIN_R = 2'b10;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic {
    IDLE,
    SCORED
  } score_state_t;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit XNOR LFSR, shift-left; the all-ones state is the lock-up state and is never reached from reset.
module lfsr10
  import tug_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= {q[LFSR_W-2:0], ~(q[TAP_HI] ^ q[TAP_LO])};
    end
  end

endmodule

// File: rtl/cyber_player.sv
// Human button conditioning, LFSR-driven CPU opponent and per-game score keeping.
module cyber_player
  import tug_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_n,
  input  logic [8:0]         sw,
  input  logic               done,
  input  logic [1:0]         winner,
  output logic [1:0]         press,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]     cnt;
  logic              tick;
  logic [LFSR_W-1:0] lfsr_q;
  logic              cpu_req;
  logic              cpu_any;
  logic              pending;

  logic              s1, s2, prev;
  logic [1:0]        fill;
  logic              armed;
  logic              fall;

  score_state_t       state, state_n;
  logic [SCORE_W-1:0] score_l_n, score_r_n;

  // Decision tick
  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .q     (lfsr_q)
  );

  assign cpu_req = tick && ({1'b0, sw} > lfsr_q);

  // Button: the edge detector only arms once the filled synchronizer has seen
  // the key released, so a key held through reset cannot produce a pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      prev  <= 1'b1;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      s1   <= key_n;
      s2   <= s1;
      prev <= s2;
      fill <= {fill[0], 1'b1};
      if (fill[1] && s2) begin
        armed <= 1'b1;
      end
    end
  end

  assign fall    = armed && prev && !s2;
  assign cpu_any = cpu_req || pending;

  // Human wins a collision; the CPU press waits one cycle in pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press   <= '0;
      pending <= 1'b0;
    end else if (done) begin
      press   <= '0;
      pending <= 1'b0;
    end else begin
      press   <= {fall, !fall && cpu_any};
      pending <= fall && cpu_any;
    end
  end

  // Score FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      score_l <= '0;
      score_r <= '0;
    end else begin
      state   <= state_n;
      score_l <= score_l_n;
      score_r <= score_r_n;
    end
  end

  always_comb begin
    state_n   = state;
    score_l_n = score_l;
    score_r_n = score_r;
    case (state)
      IDLE: begin
        if (done) begin
          state_n = SCORED;
          if (winner == WIN_L) begin
            score_l_n = sat_inc(score_l);
          end else if (winner == WIN_R) begin
            score_r_n = sat_inc(score_r);
          end
        end
      end
      SCORED: begin
        if (!done) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cyber_player.sv
// Self-checking bench for cyber_player: directed steps plus random stimulus against a behavioural model.
module tb_cyber_player;

  localparam int TD = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       key_n  = 1'b1;
  logic [8:0] sw     = '0;
  logic       done   = 1'b0;
  logic [1:0] winner = '0;
  logic [1:0] press;
  logic [2:0] score_l;
  logic [2:0] score_r;

  cyber_player #(.TICK_DIV(TD)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n),
    .sw      (sw),
    .done    (done),
    .winner  (winner),
    .press   (press),
    .score_l (score_l),
    .score_r (score_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model state: edges since reset release, key samples, LFSR value, owed CPU press, scores.
  int         e;
  logic [3:0] samp;
  logic [9:0] m_lfsr;
  bit         owed;
  bit         m_prev_done;
  int         m_l, m_r;
  logic [1:0] m_press;
  int         cpu_pulses, hum_pulses, last_hum_edge;

  logic [9:0] seq [9] = '{10'd0, 10'd1, 10'd3, 10'd7, 10'd15, 10'd31, 10'd63, 10'd127, 10'd254};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [9:0] lfsr_next(input logic [9:0] v);
    return {v[8:0], ~(v[9] ^ v[6])};
  endfunction

  task automatic model_reset();
    e           = 0;
    samp        = '1;
    m_lfsr      = '0;
    owed        = 0;
    m_prev_done = 0;
    m_l         = 0;
    m_r         = 0;
    m_press     = '0;
  endtask

  task automatic cyc();
    bit tk, h, c;
    @(posedge clk);
    e++;
    samp = {samp[2:0], key_n};
    tk = ((e - 1) % TD) == TD - 1;
    h  = (e >= 4) && samp[3] && !samp[2];
    c  = tk && ({1'b0, sw} > m_lfsr);
    if (tk) m_lfsr = lfsr_next(m_lfsr);
    if (done) begin
      m_press = 2'b00;
      owed    = 0;
    end else if (h) begin
      m_press = 2'b10;
      owed    = owed | c;
    end else if (owed | c) begin
      m_press = 2'b01;
      owed    = 0;
    end else begin
      m_press = 2'b00;
    end
    if (done && !m_prev_done) begin
      if (winner == 2'b01 && m_l < 7) m_l++;
      else if (winner == 2'b10 && m_r < 7) m_r++;
    end
    m_prev_done = done;
    @(negedge clk);
    chk("press", 16'(press), 16'(m_press));
    chk("score_l", 16'(score_l), 16'(m_l));
    chk("score_r", 16'(score_r), 16'(m_r));
    chk("lfsr", 16'(dut.lfsr_q), 16'(m_lfsr));
    chk("never_11", 16'(press == 2'b11), 16'h0);
    if (press[0]) cpu_pulses++;
    if (press[1]) begin
      hum_pulses++;
      last_hum_edge = e;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_press", 16'(press), 16'h0);
    chk("rst_score_l", 16'(score_l), 16'h0);
    chk("rst_score_r", 16'(score_r), 16'h0);
    chk("rst_lfsr", 16'(dut.lfsr_q), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    cpu_pulses = 0;
    hum_pulses = 0;
    last_hum_edge = 0;

    // LFSR sequence from reset, CPU presses after every tick with sw=511
    do_reset();
    sw = 9'd511;
    for (int i = 0; i < 36; i++) begin
      cyc();
      if (e % TD == TD - 1) chk("lfsr_seq", 16'(dut.lfsr_q), 16'(seq[e / TD]));
      if (e == 32) chk("cpu_pulses_8", 16'(cpu_pulses), 16'd8);
    end

    // sw=0: CPU never presses
    sw = 9'd0;
    cpu_pulses = 0;
    for (int i = 0; i < 2000; i++) cyc();
    chk("cpu_sw0", 16'(cpu_pulses), 16'd0);

    // sw=1: exactly one press per 1023 ticks
    sw = 9'd1;
    cpu_pulses = 0;
    for (int i = 0; i < 1023 * TD; i++) cyc();
    chk("cpu_sw1", 16'(cpu_pulses), 16'd1);

    // Key low at edge 10, held 50 cycles: one pulse after edge 12
    do_reset();
    sw = 9'd0;
    hum_pulses = 0;
    for (int i = 0; i < 9; i++) cyc();
    key_n = 1'b0;
    for (int i = 0; i < 50; i++) cyc();
    chk("hum_count", 16'(hum_pulses), 16'd1);
    chk("hum_edge", 16'(last_hum_edge), 16'd12);
    key_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc();

    // Collision on tick edge 12: human first, CPU the next cycle
    do_reset();
    sw = 9'd511;
    for (int i = 0; i < 9; i++) cyc();
    key_n = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("collide_hum", 16'(press), 16'b10);
    cyc();
    chk("collide_cpu", 16'(press), 16'b01);
    key_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc();

    // Key held through reset release: no pulse until released and pressed again
    sw = 9'd0;
    key_n = 1'b0;
    do_reset();
    hum_pulses = 0;
    for (int i = 0; i < 20; i++) cyc();
    chk("held_reset", 16'(hum_pulses), 16'd0);
    key_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    key_n = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("repress", 16'(hum_pulses), 16'd1);
    key_n = 1'b1;

    // Eight CPU wins: score_r counts once per game and saturates at 7
    do_reset();
    sw = 9'd300;
    for (int g = 0; g < 8; g++) begin
      done = 1'b1;
      winner = 2'b10;
      for (int i = 0; i < 20; i++) cyc();
      if (g == 0) chk("score_r_first", 16'(score_r), 16'd1);
      done = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
    end
    chk("score_r_sat", 16'(score_r), 16'd7);
    chk("score_l_zero", 16'(score_l), 16'd0);

    // Asynchronous reset between edges clears outputs at once
    done = 1'b1;
    winner = 2'b01;
    for (int i = 0; i < 3; i++) cyc();
    #2;
    reset = 1'b0;
    #1;
    chk("async_press", 16'(press), 16'h0);
    chk("async_score_l", 16'(score_l), 16'h0);
    chk("async_score_r", 16'(score_r), 16'h0);
    chk("async_lfsr", 16'(dut.lfsr_q), 16'h0);
    done = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Random play
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) sw = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 5) == 0) key_n = ~key_n;
      if ($urandom_range(0, 39) == 0) begin
        done = ~done;
        winner = 2'($urandom_range(0, 3));
      end
      cyc();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
